// File: rtl/aes_inv_cbc_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_cbc_ctrl
//   Block controller that sits in front of an iterative AES inverse cipher
//   core. It accepts one ciphertext block at a time and hands it to the core
//   with a single load strobe. When the core finishes, the controller XORs the
//   result with the chaining value to give the plaintext, and holds that
//   plaintext until the consumer takes it. The chaining value is the IV or
//   the previous ciphertext block.
//
//   Configuration macro: AES_INV_CBC_EN
//     defined   : CBC decryption (chaining register, iv/iv_ld honoured)
//     undefined : ECB decryption (no chaining register, iv/iv_ld unused
//                 except that iv_ld still holds off in_ready)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   kld_in         key-load request; passed to the core, aborts any block
//   iv_ld, iv      load the chaining register (IDLE only)
//   in_valid/in_ready/in_data     ciphertext input handshake
//   core_kld, core_ld, core_text_in   drive the inverse cipher core
//   core_done, core_text_out          core completion pulse and result
//   out_valid/out_ready/out_data  plaintext output handshake
//   key_ok         core key schedule complete
// ---------------------------------------------------------------------------
module aes_inv_cbc_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld_in,
    input  logic         iv_ld,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         core_kld,
    output logic         core_ld,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         key_ok
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    state_t       state_q, state_d;
    logic [3:0]   key_cnt_q, key_cnt_d;
    logic         key_seen_q, key_seen_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] res_q, res_d;
`ifdef AES_INV_CBC_EN
    logic [127:0] chain_q, chain_d;
`else
    logic         unused_iv;
    assign unused_iv = ^iv;
`endif

    assign core_kld     = kld_in;
    assign core_text_in = ct_q;
    assign out_data     = res_q;
    // key_seen_q is set only by kld_in, so a reset leaves the key invalid
    // until the next key load. The key is also invalid while kld_in is high,
    // because the core is reloading its key schedule in that cycle.
    assign key_ok       = key_seen_q && (key_cnt_q == 4'd0) && !kld_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            key_cnt_q  <= 4'd0;
            key_seen_q <= 1'b0;
            ct_q       <= '0;
            res_q      <= '0;
`ifdef AES_INV_CBC_EN
            chain_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            key_cnt_q  <= key_cnt_d;
            key_seen_q <= key_seen_d;
            ct_q       <= ct_d;
            res_q      <= res_d;
`ifdef AES_INV_CBC_EN
            chain_q    <= chain_d;
`endif
        end
    end

    // Key-schedule wait counter
    always_comb begin
        key_cnt_d  = key_cnt_q;
        key_seen_d = key_seen_q;
        if (kld_in) begin
            key_cnt_d  = 4'd13;
            key_seen_d = 1'b1;
        end else if (key_cnt_q != 4'd0) begin
            key_cnt_d = key_cnt_q - 4'd1;
        end
    end

    // Block FSM. A key load overrides everything: the in-flight block is
    // dropped, and no output or chaining register is updated.
    always_comb begin
        state_d   = state_q;
        ct_d      = ct_q;
        res_d     = res_q;
`ifdef AES_INV_CBC_EN
        chain_d   = chain_q;
`endif
        in_ready  = 1'b0;
        core_ld   = 1'b0;
        out_valid = 1'b0;
        if (kld_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready = key_ok && !iv_ld;
`ifdef AES_INV_CBC_EN
                    if (iv_ld) chain_d = iv;
`endif
                    if (in_valid && in_ready) begin
                        ct_d    = in_data;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    core_ld = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    if (core_done) begin
`ifdef AES_INV_CBC_EN
                        res_d = core_text_out ^ chain_q;
`else
                        res_d = core_text_out;
`endif
                        state_d = OUT;
                    end
                end
                OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
`ifdef AES_INV_CBC_EN
                        chain_d = ct_q;
`endif
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cbc_ctrl.sv
module tb_aes_inv_cbc_ctrl;

    localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_PT2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
`ifdef AES_INV_CBC_EN
    localparam bit CBC = 1'b1;
`else
    localparam bit CBC = 1'b0;
`endif

    logic         clk, rst, kld_in, iv_ld, in_valid, out_ready, core_done;
    logic [127:0] iv, in_data, core_text_out;
    logic         in_ready, core_kld, core_ld, out_valid, key_ok;
    logic [127:0] core_text_in, out_data;

    int tests = 0;
    int fails = 0;

    // core model controls
    int core_lat = 2;
    int spur_req = 0;
    int spur_ack = 0;
    int done_cnt = 0;

    // chaining value the reference model expects the DUT to hold
    logic [127:0] m_chain = '0;

    aes_inv_cbc_ctrl dut (
        .clk(clk), .rst(rst), .kld_in(kld_in), .iv_ld(iv_ld), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_kld(core_kld), .core_ld(core_ld), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_ok(key_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the inverse cipher: the FIPS-197 vector decrypts to its
    // known plaintext, and every other block goes through a fixed
    // invertible scramble.
    function automatic logic [127:0] core_dec(input logic [127:0] x);
        if (x == VEC_CT) return VEC_PT;
        return {x[63:0], x[127:64]} ^ 128'h5a5a_3c3c_0f0f_a5a5_1234_5678_9abc_def0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model: captures on core_ld and pulses core_done after core_lat
    // idle cycles. A block the DUT has aborted still completes, which
    // produces a stray done pulse. On request, the model also emits an
    // unsolicited done pulse.
    initial begin : core_model
        bit busy;
        int cnt;
        logic [127:0] buf_q;
        busy = 0; cnt = 0; buf_q = '0;
        core_done = 1'b0;
        core_text_out = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_ld) begin
                busy = 1; cnt = core_lat; buf_q = core_dec(core_text_in);
            end else if (busy) begin
                if (cnt == 0) begin
                    core_done = 1'b1; core_text_out = buf_q; busy = 0; done_cnt++;
                end else begin
                    cnt--;
                end
            end else if (spur_req != spur_ack) begin
                core_done = 1'b1; core_text_out = rnd128(); spur_ack++; done_cnt++;
            end
        end
    end

    task automatic key_load_wait();
        bit bad;
        @(negedge clk); kld_in = 1'b1;
        #1;
        bad = key_ok;
        @(negedge clk); kld_in = 1'b0;
        for (int k = 1; k < 14; k++) begin
            #1; if (key_ok) bad = 1;
            @(negedge clk);
        end
        #1;
        tests++;
        if (bad || key_ok !== 1'b1) begin
            fails++;
            $display("FAIL key_wait: key_ok early=%0b at14=%0b required early=0 at14=1", bad, key_ok);
        end
        $display("[TB] key load: key_ok after 14 cycles = %0b", key_ok);
    endtask

    // Send one block and check its plaintext, the single load strobe, the
    // latencies, and that the output holds for `hold` cycles.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                             input int lat, input int hold, input bit poke_iv);
        bit got, prev_done, lat_bad, hold_bad;
        int ld_cnt;
        logic [127:0] held;
        core_lat = lat;
        @(negedge clk); in_valid = 1'b1; in_data = ct;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1; if (in_ready) got = 1; else @(negedge clk);
        end
        tests++;
        if (!got) begin fails++; $display("FAIL accept: in_ready=%0b required 1", in_ready); end
        @(negedge clk); in_valid = 1'b0; in_data = rnd128();
        got = 0; prev_done = 0; lat_bad = 0; ld_cnt = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (i == 0 && !core_ld) lat_bad = 1;
            if (core_ld) ld_cnt++;
            if (out_valid) begin
                got = 1;
                if (!prev_done) lat_bad = 1;
            end else begin
                prev_done = core_done;
                if (poke_iv && i == 1) begin iv_ld = 1'b1; iv = rnd128(); end
                else iv_ld = 1'b0;
                @(negedge clk);
            end
        end
        iv_ld = 1'b0;
        tests++;
        if (!got || ld_cnt != 1 || lat_bad) begin
            fails++;
            $display("FAIL block_timing: out_valid=%0b core_ld pulses=%0d latency_err=%0b required 1/1/0",
                     got, ld_cnt, lat_bad);
        end
        tests++;
        if (out_data !== exp) begin
            fails++;
            $display("FAIL block_data: out_data=%h required %h", out_data, exp);
        end
        held = out_data; hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            if (!out_valid || out_data !== held || in_ready || core_ld) hold_bad = 1;
        end
        tests++;
        if (hold_bad) begin
            fails++;
            $display("FAIL hold: out_valid=%0b out_data=%h in_ready=%0b core_ld=%0b required 1/%h/0/0",
                     out_valid, out_data, in_ready, core_ld, held);
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL release: out_valid=%0b required 0", out_valid); end
        m_chain = ct;
        $display("[TB] block ct=%h out=%h exp=%h lat=%0d hold=%0d", ct, out_data, exp, lat, hold);
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (key_ok !== 1'b0 || in_ready !== 1'b0 || core_ld !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_state: key_ok=%0b in_ready=%0b core_ld=%0b out_valid=%0b out_data=%h required all 0",
                     key_ok, in_ready, core_ld, out_valid, out_data);
        end
        @(negedge clk); rst = 1'b1; in_valid = 1'b1; in_data = VEC_CT;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1; if (in_ready || key_ok || core_ld) bad = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (bad) begin fails++; $display("FAIL no_key: in_ready/key_ok/core_ld went to 1, required 0"); end
        $display("[TB] reset and no-key check done");
        m_chain = '0;
    endtask

    task automatic test_vectors();
        @(negedge clk); iv_ld = 1'b1; iv = '0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL iv_ld_ready: in_ready=%0b required 0", in_ready); end
        @(negedge clk); iv_ld = 1'b0;
        if (CBC) m_chain = '0;
        run_block(VEC_CT, VEC_PT, 3, 2, 0);
        run_block(VEC_CT, CBC ? VEC_PT2 : VEC_PT, 0, 20, 0);
    endtask

    task automatic test_random();
        logic [127:0] ct, v;
        @(negedge clk); iv_ld = 1'b1; v = rnd128(); iv = v;
        @(negedge clk); iv_ld = 1'b0;
        if (CBC) m_chain = v;
        for (int b = 0; b < 8; b++) begin
            ct = rnd128();
            run_block(ct, core_dec(ct) ^ (CBC ? m_chain : 128'h0),
                      $urandom_range(0, 6), $urandom_range(0, 4), b[0]);
        end
    endtask

    task automatic test_abort();
        bit bad, got;
        int d0;
        core_lat = 6;
        @(negedge clk); in_valid = 1'b1; in_data = rnd128();
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1; if (in_ready) got = 1; else @(negedge clk);
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        kld_in = 1'b1;
        #1;
        bad = out_valid || key_ok;
        @(negedge clk); kld_in = 1'b0;
        for (int k = 1; k < 14; k++) begin
            #1; if (key_ok || out_valid || in_ready) bad = 1;
            @(negedge clk);
        end
        #1;
        tests++;
        if (!got || bad || key_ok !== 1'b1 || in_ready !== 1'b1 || done_cnt == d0) begin
            fails++;
            $display("FAIL abort: accepted=%0b window_err=%0b key_ok=%0b in_ready=%0b stray_done=%0d required 1/0/1/1/>0",
                     got, bad, key_ok, in_ready, done_cnt - d0);
        end
        spur_req++;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; if (out_valid || core_ld) bad = 1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL spurious_done: out_valid/core_ld=1 required 0"); end
        $display("[TB] abort during RUN: chain kept, key_ok=%0b", key_ok);
        run_block(VEC_CT, VEC_PT ^ (CBC ? m_chain : 128'h0), 1, 1, 0);
    endtask

    task automatic test_midop_reset();
        bit bad, got;
        core_lat = 5;
        @(negedge clk); in_valid = 1'b1; in_data = rnd128();
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1; if (in_ready) got = 1; else @(negedge clk);
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1; if (key_ok || out_valid || in_ready || out_data !== '0) bad = 1;
            @(negedge clk);
        end
        tests++;
        if (!got || bad) begin
            fails++;
            $display("FAIL midop_reset: accepted=%0b err=%0b key_ok=%0b out_valid=%0b required 1/0/0/0",
                     got, bad, key_ok, out_valid);
        end
        $display("[TB] reset mid-operation: key_ok=%0b out_valid=%0b", key_ok, out_valid);
        m_chain = '0;
        key_load_wait();
        run_block(VEC_CT, VEC_PT, 2, 0, 0);
    endtask

    initial begin
        rst = 1'b0; kld_in = 1'b0; iv_ld = 1'b0; iv = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        key_load_wait();
        test_vectors();
        test_random();
        test_abort();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
